// File: rtl/life_pkg.sv
// Shared types and default sizes for the Game-of-Life generation sequencer.
package life_pkg;

  localparam int ROWS_DEF  = 8;
  localparam int COLS_DEF  = 8;
  localparam int CNT_W_DEF = 16;
  localparam int DIV_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_EVAL,
    ST_PAUSE,
    ST_DONE
  } state_e;

  // Why a run halted on its own, in descending priority.
  typedef enum logic [2:0] {
    HALT_NONE,
    HALT_EXTINCT,
    HALT_STABLE,
    HALT_OSC2,
    HALT_LIMIT
  } halt_e;

endpackage

// File: rtl/life_rate_div.sv
// Generation rate divider: counts up to rate_div, flags terminal count, wraps on it.
module life_rate_div
  import life_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] rate_div,
  output logic             tc
);

  logic [DIV_W-1:0] count;

  assign tc = (count == rate_div);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/life_gen_ctrl.sv
// Generation sequencer for the Game-of-Life array: reload, pacing, run/pause/step/stop, halt detection.
// Defining LIFE_GEN_CTRL_OSC2_EN adds period-2 oscillator detection and the osc2 output.
module life_gen_ctrl
  import life_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 step,
  input  logic                 stop,
  input  logic [CNT_W-1:0]     max_gens,
  input  logic [DIV_W-1:0]     rate_div,
  input  logic [ROWS*COLS-1:0] grid_state,
  output logic                 cell_rst_n,
  output logic                 gen_tick,
  output logic [CNT_W-1:0]     gen_count,
  output logic                 busy,
  output logic                 done,
  output logic                 extinct,
  output logic                 stable
`ifdef LIFE_GEN_CTRL_OSC2_EN
  ,
  output logic                 osc2
`endif
);

  localparam int CELLS = ROWS * COLS;

  state_e           state, state_nxt;
  halt_e            halt;
  logic [CELLS-1:0] prev;
  logic             pause_latch;
  logic             abort;
  logic             tc;
`ifdef LIFE_GEN_CTRL_OSC2_EN
  logic [CELLS-1:0] prev2;
`endif

  assign abort = stop && (state != ST_IDLE);

  life_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_LOAD || abort),
    .en      (state == ST_RUN && !stop),
    .rate_div(rate_div),
    .tc      (tc)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    halt = HALT_NONE;
    if (grid_state == '0)                              halt = HALT_EXTINCT;
    else if (grid_state == prev)                       halt = HALT_STABLE;
`ifdef LIFE_GEN_CTRL_OSC2_EN
    else if (grid_state == prev2)                      halt = HALT_OSC2;
`endif
    else if (max_gens != '0 && gen_count == max_gens)  halt = HALT_LIMIT;
  end

  always_comb begin
    state_nxt = state;
    gen_tick  = 1'b0;
    case (state)
      ST_IDLE:  if (start && !stop) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (tc) begin
          gen_tick  = 1'b1;
          state_nxt = ST_EVAL;
        end else if (pause) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_EVAL: begin
        if (stop)                   state_nxt = ST_IDLE;
        else if (halt != HALT_NONE) state_nxt = ST_DONE;
        else if (pause_latch)       state_nxt = ST_PAUSE;
        else                        state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          state_nxt = ST_RUN;
        end else if (step) begin
          gen_tick  = 1'b1;
          state_nxt = ST_EVAL;
        end
      end
      ST_DONE: begin
        if (stop)       state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: the grid snapshots are reset too; a stale snapshot could fake a still-life on gen 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev        <= '0;
      gen_count   <= '0;
      extinct     <= 1'b0;
      stable      <= 1'b0;
      pause_latch <= 1'b0;
`ifdef LIFE_GEN_CTRL_OSC2_EN
      prev2       <= '0;
      osc2        <= 1'b0;
`endif
    end else begin
      if (state == ST_LOAD) begin
        prev      <= '0;
        gen_count <= '0;
`ifdef LIFE_GEN_CTRL_OSC2_EN
        prev2     <= '0;
`endif
      end
      if (gen_tick) begin
        prev <= grid_state;
`ifdef LIFE_GEN_CTRL_OSC2_EN
        prev2 <= prev;
`endif
        if (gen_count != '1) gen_count <= gen_count + 1'b1;
      end
      if (state == ST_RUN && pause && !stop)   pause_latch <= 1'b1;
      if (state == ST_PAUSE && start && !stop) pause_latch <= 1'b0;
      if (state == ST_EVAL && !stop) begin
        case (halt)
          HALT_EXTINCT: extinct <= 1'b1;
          HALT_STABLE:  stable  <= 1'b1;
`ifdef LIFE_GEN_CTRL_OSC2_EN
          HALT_OSC2:    osc2    <= 1'b1;
`endif
          default: ;
        endcase
      end
      // Reload and abort both start the next run from a clean slate; gen_count survives an abort.
      if (state == ST_LOAD || abort) begin
        extinct     <= 1'b0;
        stable      <= 1'b0;
        pause_latch <= 1'b0;
`ifdef LIFE_GEN_CTRL_OSC2_EN
        osc2        <= 1'b0;
`endif
      end
    end
  end

  assign cell_rst_n = (state != ST_LOAD);
  assign busy       = (state == ST_LOAD) || (state == ST_RUN) ||
                      (state == ST_EVAL) || (state == ST_PAUSE);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_life_gen_ctrl.sv
// Self-checking bench for life_gen_ctrl: directed table, corner sequences, randomized run vs. a cycle model.
module tb_life_gen_ctrl;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CNT_W = 16;
  localparam int DIV_W = 24;

`ifdef LIFE_GEN_CTRL_OSC2_EN
  localparam bit OSC = 1'b1;
`else
  localparam bit OSC = 1'b0;
`endif

  localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0, pause = 1'b0, step = 1'b0, stop = 1'b0;
  logic [CNT_W-1:0]  max_gens = '0;
  logic [DIV_W-1:0]  rate_div = '0;
  logic [63:0]       grid_state;
  logic [63:0]       init_pat = '0;
  logic              cell_rst_n, gen_tick, busy, done, extinct, stable;
  logic [CNT_W-1:0]  gen_count;
  logic              osc_o;

  int n_vec = 0;
  int n_err = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  life_gen_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .step      (step),
    .stop      (stop),
    .max_gens  (max_gens),
    .rate_div  (rate_div),
    .grid_state(grid_state),
    .cell_rst_n(cell_rst_n),
    .gen_tick  (gen_tick),
    .gen_count (gen_count),
    .busy      (busy),
    .done      (done),
    .extinct   (extinct),
    .stable    (stable)
`ifdef LIFE_GEN_CTRL_OSC2_EN
    ,
    .osc2      (osc_o)
`endif
  );

`ifndef LIFE_GEN_CTRL_OSC2_EN
  assign osc_o = 1'b0;
`endif

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] n;
    int k;
    n = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS)
              k += int'(g[(r + dr) * COLS + c + dc]);
        n[r * COLS + c] = (k == 3) || (k == 2 && g[r * COLS + c]);
      end
    end
    return n;
  endfunction

  // Cell array stand-in: reloads on either reset, advances one generation per gen_tick.
  always @(posedge clk or negedge rst) begin
    if (!rst)             grid_state <= init_pat;
    else if (!cell_rst_n) grid_state <= init_pat;
    else if (gen_tick)    grid_state <= life_next(grid_state);
  end

  always @(negedge clk) if (rst && gen_tick) tick_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (mode + countdown of RUN cycles to the next tick) ----------------
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_EVAL, M_PAUSE, M_DONE} mode_e;
  mode_e       m_mode;
  int          m_left, m_count;
  logic [63:0] m_prev, m_prev2;
  bit          m_ext, m_stb, m_osc, m_latch, exp_tick;
  logic [63:0] exp_v, act_v;

  task automatic m_abort();
    m_mode = M_IDLE; m_ext = 0; m_stb = 0; m_osc = 0; m_latch = 0;
  endtask

  task automatic m_gen(input logic [63:0] g);
    m_prev2 = m_prev;
    m_prev  = g;
    if (m_count < 65535) m_count++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_mode = M_IDLE; m_left = 0; m_count = 0; m_prev = '0; m_prev2 = '0;
      m_ext = 0; m_stb = 0; m_osc = 0; m_latch = 0;
    end
    exp_tick = (m_mode == M_RUN && !stop && m_left == 1) ||
               (m_mode == M_PAUSE && !stop && !start && step);
    exp_v = {41'd0, m_mode != M_LOAD, exp_tick, 16'(m_count),
             m_mode inside {M_LOAD, M_RUN, M_EVAL, M_PAUSE}, m_mode == M_DONE, m_ext, m_stb, m_osc};
    act_v = {41'd0, cell_rst_n, gen_tick, gen_count, busy, done, extinct, stable, osc_o};
    check("cycle", act_v, exp_v);
    if (rst) begin
      case (m_mode)
        M_IDLE: if (start && !stop) m_mode = M_LOAD;
        M_LOAD: begin
          m_count = 0; m_prev = '0; m_prev2 = '0;
          m_ext = 0; m_stb = 0; m_osc = 0; m_latch = 0;
          m_left = int'(rate_div) + 1;
          m_mode = stop ? M_IDLE : M_RUN;
        end
        M_RUN: begin
          if (stop) m_abort();
          else begin
            if (pause) m_latch = 1;
            if (m_left == 1) begin
              m_gen(grid_state);
              m_left = int'(rate_div) + 1;
              m_mode = M_EVAL;
            end else begin
              m_left--;
              if (pause) m_mode = M_PAUSE;
            end
          end
        end
        M_EVAL: begin
          if (stop) m_abort();
          else if (grid_state == 0)       begin m_ext = 1; m_mode = M_DONE; end
          else if (grid_state == m_prev)  begin m_stb = 1; m_mode = M_DONE; end
          else if (OSC && grid_state == m_prev2) begin m_osc = 1; m_mode = M_DONE; end
          else if (max_gens != 0 && m_count == int'(max_gens)) m_mode = M_DONE;
          else m_mode = m_latch ? M_PAUSE : M_RUN;
        end
        M_PAUSE: begin
          if (stop) m_abort();
          else if (start) begin m_latch = 0; m_mode = M_RUN; end
          else if (step) begin m_gen(grid_state); m_mode = M_EVAL; end
        end
        M_DONE: begin
          if (stop) m_abort();
          else if (start) m_mode = M_LOAD;
        end
        default: m_abort();
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(); start = 1'b1; cyc(); start = 1'b0; endtask
  task automatic pulse_stop();  stop  = 1'b1; cyc(); stop  = 1'b0; endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic configure(input logic [63:0] pat, input int rd, input int mg);
    init_pat = pat;
    rate_div = DIV_W'(rd);
    max_gens = CNT_W'(mg);
  endtask

  typedef struct {
    logic [63:0] pat;
    int          rd;
    int          mg;
    int          cnt;
    bit          ext;
    bit          stb;
    bit          osc;
  } case_t;

  case_t tbl[8];
  int    n_wait, ticks_at;
  int    r;

  initial begin
    tbl[0] = '{BLINKER, 0, 4, OSC ? 2 : 4, 1'b0, 1'b0, OSC};
    tbl[1] = '{SINGLE,  0, 0, 1,           1'b1, 1'b0, 1'b0};
    tbl[2] = '{BLOCK,   0, 0, 1,           1'b0, 1'b1, 1'b0};
    tbl[3] = '{BLINKER, 2, 3, OSC ? 2 : 3, 1'b0, 1'b0, OSC};
    tbl[4] = '{BLINKER, 1, 1, 1,           1'b0, 1'b0, 1'b0};
    tbl[5] = '{64'd0,   5, 0, 1,           1'b1, 1'b0, 1'b0};
    tbl[6] = '{GLIDER,  0, 5, 5,           1'b0, 1'b0, 1'b0};
    tbl[7] = '{BLOCK,   3, 2, 1,           1'b0, 1'b1, 1'b0};

    repeat (2) cyc();
    check("reset_state", {cell_rst_n, gen_tick, gen_count, busy, done, extinct, stable},
          {1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      configure(tbl[i].pat, tbl[i].rd, tbl[i].mg);
      tick_cnt = 0;
      pulse_start();
      wait_done(400);
      check($sformatf("case%0d_done", i),    done, 1);
      check($sformatf("case%0d_count", i),   gen_count, tbl[i].cnt);
      check($sformatf("case%0d_flags", i),   {extinct, stable, osc_o}, {tbl[i].ext, tbl[i].stb, tbl[i].osc});
      check($sformatf("case%0d_ticks", i),   tick_cnt, tbl[i].cnt);
      repeat (6) cyc();
      check($sformatf("case%0d_held", i),    {done, gen_count, 32'(tick_cnt)}, {1'b1, 16'(tbl[i].cnt), 32'(tbl[i].cnt)});
    end

    // Stop out of DONE clears flags but keeps the generation count.
    configure(SINGLE, 0, 0);
    pulse_start();
    wait_done(100);
    check("ext_before_stop", extinct, 1);
    pulse_stop();
    check("stop_clears_flags", {busy, done, extinct, stable}, 4'b0000);
    check("stop_keeps_count", gen_count, 1);

    // Pause mid-divider, three single steps, then resume with the remaining divider cycles.
    configure(GLIDER, 9, 0);
    tick_cnt = 0;
    pulse_start();
    repeat (3) cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    repeat (4) cyc();
    check("paused_idle", {busy, done, 32'(tick_cnt)}, {1'b1, 1'b0, 32'd0});
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      #1;
      check($sformatf("step%0d_tick", s), gen_tick, 1);
      cyc();
      step = 1'b0;
      cyc();
    end
    repeat (3) cyc();
    check("steps_count", {gen_count, 32'(tick_cnt)}, {16'd3, 32'd3});
    pulse_start();
    n_wait = 0;
    while (!gen_tick && n_wait < 50) begin
      cyc();
      n_wait++;
    end
    check("resume_latency", n_wait, (9 + 1) - 3 - 1);
    cyc();
    check("resume_count", gen_count, 4);
    pulse_stop();

    // Stop coinciding with the divider terminal count swallows the tick.
    configure(BLINKER, 3, 0);
    tick_cnt = 0;
    pulse_start();
    repeat (4) cyc();
    check("tc_armed", gen_tick, 1);
    stop = 1'b1;
    #1;
    check("tc_stop_no_tick", gen_tick, 0);
    cyc();
    stop = 1'b0;
    check("tc_stop_idle", {busy, done, extinct, stable, gen_count, 32'(tick_cnt)}, {4'b0000, 16'd0, 32'd0});

    // Asynchronous reset in the middle of a run.
    configure(GLIDER, 0, 0);
    pulse_start();
    repeat (7) cyc();
    ticks_at = tick_cnt;
    check("pre_reset_running", {busy, 1'b1}, {1'b1, gen_count != 0});
    #2 rst = 1'b0;
    #1;
    check("mid_reset", {cell_rst_n, gen_tick, gen_count, busy, done}, {1'b1, 1'b0, 16'd0, 1'b0, 1'b0});
    @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // Randomized commands; the negedge model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      if (!busy && $urandom_range(0, 3) == 0)
        configure({$urandom, $urandom} & {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 8));
      r = $urandom_range(0, 99);
      start = (r < 5);
      pause = (r >= 5 && r < 12);
      step  = (r >= 12 && r < 24);
      stop  = (r >= 24 && r < 26);
      cyc();
    end
    {start, pause, step, stop} = 4'b0000;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
Generation sequencer for the Game-of-Life cell array. It reloads the array's initial pattern and paces generations with a programmable rate divider. It supports run, pause, single-step and stop, counts generations, and halts automatically on extinction, a still-life or a generation limit. It sits between the top-level control inputs and the cell array's reset and clock-enable.

Parameters:
ROWS, 8, grid rows
COLS, 8, grid columns
CNT_W, 16, generation counter / limit width
DIV_W, 24, rate divider width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  IDLE/DONE: load and run; PAUSE: resume
pause  in  1  request pause after current generation
step  in  1  PAUSE only: advance exactly one generation
stop  in  1  abort to IDLE
max_gens  in  CNT_W  generation limit, 0 = unlimited
rate_div  in  DIV_W  cycles between generations minus 1
grid_state  in  ROWS*COLS  current state of every cell, row-major
cell_rst_n  out  1  active-low reload strobe, ANDed with rst at array
gen_tick  out  1  one-cycle clock-enable to the array
gen_count  out  CNT_W  generations completed since load
busy  out  1  state is LOAD/RUN/EVAL/PAUSE
done  out  1  state is DONE
extinct  out  1  halted because grid_state == 0
stable  out  1  halted because grid unchanged

Behaviour:
- Reset: state IDLE; cell_rst_n=1, gen_tick=0, gen_count=0, divider=0, prev snapshot=0, extinct=stable=0, pause latch=0.
- Command priority in the same cycle: stop > start > pause > step.
- IDLE: start -> LOAD.
- LOAD (exactly 1 cycle):
  - cell_rst_n=0.
  - Clear gen_count, divider, flags and pause latch.
  - -> RUN.
- RUN:
  - divider increments each cycle. When divider==rate_div: gen_tick=1, divider<=0, prev<=grid_state (pre-update value), gen_count++ (saturates at all-ones), -> EVAL.
  - rate_div=0 gives a tick every other cycle (RUN, EVAL alternate).
  - pause sets the pause latch. If pause is seen on a non-tick cycle, go to PAUSE next cycle with the divider held.
- EVAL (1 cycle; grid_state now holds the new generation):
  - If grid_state==0: extinct<=1, -> DONE.
  - Else if grid_state==prev: stable<=1, -> DONE.
  - Else if max_gens!=0 and gen_count==max_gens: -> DONE.
  - Else if pause latch set: -> PAUSE.
  - Else: -> RUN.
  - extinct takes precedence over stable; both may not be set together.
- PAUSE:
  - step: gen_tick=1 in the same cycle, with snapshot and count updated as in RUN; -> EVAL, which returns to PAUSE because the latch is still set.
  - start: clear latch, -> RUN with the divider resumed from its held value.
- DONE:
  - Outputs and flags are held.
  - start -> LOAD.
  - stop -> IDLE.
- stop in any non-IDLE state:
  - -> IDLE next cycle and clear flags; gen_count is held.
  - gen_tick is suppressed in a cycle where stop is asserted.
- Reset mid-operation aborts immediately to the reset values above.
- Ignored commands: step outside PAUSE, pause outside RUN, start in RUN/EVAL/LOAD.
- gen_tick and cell_rst_n are never asserted in the same cycle.

Optional Feature:
LIFE_GEN_CTRL_OSC2_EN
- Defined:
  - Keep a second snapshot prev2 (shifted from prev on each tick).
  - In EVAL, grid_state==prev2 with grid_state!=prev sets output osc2 and goes to DONE.
  - osc2 has the same priority rules, below stable.
  - This adds port osc2 (out, 1).
- Undefined: no prev2 register and no osc2 port; period-2 oscillators run until max_gens or stop.

Decomposition:
- Package life_pkg:
  - state enum (IDLE, LOAD, RUN, EVAL, PAUSE, DONE)
  - halt-reason encoding
  - default ROWS/COLS/CNT_W/DIV_W localparams
- Sub-module life_rate_div:
  - Divider counter with clear, hold and terminal-count output.
  - The FSM and snapshot compare remain in life_gen_ctrl.

Test Plan:
- Blinker on 8x8, rate_div=0, max_gens=4, start -> one cell_rst_n low cycle; gen_tick every 2 cycles; gen_count=4; done=1 with extinct=0 and stable=0.
- Single live cell, start -> after the first tick, EVAL sees 0; extinct=1, done=1, gen_count=1.
- 2x2 block still-life, max_gens=0 -> stable=1 after gen 1; no further ticks.
- rate_div=9, pause asserted mid-divider -> PAUSE with the divider held; three step pulses give three single-cycle gen_ticks and gen_count+3; start resumes with the remaining divider cycles.
- stop on the same cycle as the divider terminal count -> no gen_tick; IDLE next cycle; flags cleared.
- With LIFE_GEN_CTRL_OSC2_EN defined, blinker and max_gens=0 -> osc2=1 at gen 2, done=1.
